// File: rtl/rs_rx.sv
// UART receiver: 8N1, LSB first, idle-high line; recovers bytes from the async rx pin.
// Latency: data/dataready land one cycle after the mid-stop-bit sample (T0+HALF+9*DIVIDER).
// Backpressure: none; each byte is strobed once and the consumer must take it that cycle.
module rs_rx #(
  parameter int DIVIDER = 434,
  parameter int HALF    = DIVIDER / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       dataready,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF_END = 16'(HALF - 1);
  localparam logic [15:0] BIT_END  = 16'(DIVIDER - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rx_meta;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        half_hit;
  logic        bit_hit;
  logic        take_bit;
  logic        stop_good;
  logic        stop_bad;

  // Two-flop synchronizer; resets to the idle-high level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign half_hit = (cnt == HALF_END);
  assign bit_hit  = (cnt == BIT_END);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: start qualification at mid start bit, 8 data samples, stop check, break wait.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_hit && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:    if (bit_hit) state_nxt = rx_s ? IDLE : BRK;
      BRK:     if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/strobe decode from the current state.
  always_comb begin
    busy      = (state != IDLE);
    take_bit  = (state == DATA) && bit_hit;
    stop_good = (state == STOP) && bit_hit && rx_s;
    stop_bad  = (state == STOP) && bit_hit && !rx_s;
  end

  // Datapath: tick counter, bit counter, shift register and registered byte/strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 16'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      data      <= 8'd0;
      dataready <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dataready <= stop_good;
      frame_err <= stop_bad;
      if (stop_good) data <= shreg;
      case (state)
        START: cnt <= half_hit ? 16'd0 : cnt + 16'd1;
        DATA,
        STOP:  cnt <= bit_hit ? 16'd0 : cnt + 16'd1;
        default: cnt <= 16'd0;
      endcase
      if (state == IDLE) begin
        bit_cnt <= 3'd0;
      end else if (take_bit) begin
        // Bit counter wraps to 0 after the eighth sample, ready for the next frame.
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: doc/rs_rx.md
# rs_rx

UART receiver for the serial debug link: 8 data bits, no parity, 1 stop bit, LSB first, line idle high. It sits directly downstream of the serial transmit line and recovers bytes from the asynchronous `rx` pin. Each byte is presented on a parallel bus with a one-cycle `dataready` strobe, using the same byte/strobe convention as the transmitter input. Stop-bit errors are flagged, not delivered.

## Interface
- `DIVIDER`, 434: clock cycles per bit (115200 bit/s at 50 MHz). Legal range 4..65535.
- `HALF`, DIVIDER/2 (integer division): cycles from start detection to the start-bit mid-point sample.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial line, idle high.
- `data`  output  8  last correctly framed byte; holds until the next good frame.
- `dataready`  output  1  one-cycle pulse when `data` has just been updated.
- `frame_err`  output  1  one-cycle pulse when a stop bit is sampled low.
- `busy`  output  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). On reset, both flops load 1.
- 16-bit tick counter, 3-bit bit counter, 8-bit shift register (shifts right; the sampled bit enters at bit 7).
- States:
  - IDLE: counter = 0. When `rx_s` = 0, go to START.
  - START: counter increments each cycle. When counter = HALF-1, sample `rx_s`.
    - 0: clear the counter and go to DATA.
    - 1: false start; go to IDLE with no outputs.
  - DATA: when counter = DIVIDER-1, sample `rx_s` into the shift register, clear the counter and increment the bit counter. After the 8th sample, go to STOP.
  - STOP: when counter = DIVIDER-1, sample `rx_s`.
    - 1: load `data` from the shift register, pulse `dataready` and go to IDLE.
    - 0: pulse `frame_err`, leave `data` unchanged and go to BREAK.
  - BREAK: wait for `rx_s` = 1, then go to IDLE. A line held low (break condition) never starts a new frame.
- Other encodings: go to IDLE.
- `dataready` and `frame_err` are registered and mutually exclusive, and each is never high for two consecutive cycles.
- Reset at any point: state IDLE, counters 0, shift register 0. Any partial frame is discarded.

## Timing
- Reset values: `data` = 0x00, `dataready` = 0, `frame_err` = 0, `busy` = 0.
- Let edge T0 be the clock edge at which IDLE sees `rx_s` = 0. This is 2 edges after the first edge that registers the pin low.
  - Start sample: T0+HALF.
  - Data bit k (k = 0..7): T0+HALF+(k+1)·DIVIDER.
  - Stop sample: T0+HALF+9·DIVIDER.
- `dataready` or `frame_err` is high for exactly the one cycle following the stop-sample edge. `data` is valid in that same cycle.
- `busy` rises the cycle after T0. It falls the cycle after the stop-sample edge on a good frame, or the cycle after `rx_s` returns high on a frame error.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge arriving half a bit after the stop sample is detected. There is no dead time beyond one cycle.
- Tolerance: the sampling scheme accepts a transmitter bit-period error of up to ±4%.

## Test plan
All scenarios run with DIVIDER = 16, HALF = 8, unless stated otherwise.
- Clean frame 0xA5, ideal timing -> single `dataready` pulse, `data` = 0xA5, `frame_err` = 0, `busy` high about 9.5 bit times.
- Low glitch of 4 cycles on an idle line -> false start rejected, `busy` back to 0 within 10 cycles, no `dataready`, no `frame_err`, `data` unchanged.
- Frame 0x3C with stop bit 0, then line held low 100 cycles, then high, then frame 0x01:
  - one `frame_err` pulse; `data` stays 0xA5.
  - no start detected while the line is low.
  - 0x01 then received with `dataready`.
- Back-to-back frames 0x00, 0xFF, 0x55 with one stop bit each -> three `dataready` pulses with the matching bytes.
- `rst` asserted for 1 cycle during data bit 4 of a frame:
  - all outputs 0 the next cycle.
  - the remainder of that frame produces no `dataready` (it may produce `frame_err` or nothing).
  - the following frame 0x5A decodes correctly.
- DIVIDER = 434, frame 0xC3 sent with bit period 417 and then with bit period 451 (±4%) -> both decode to 0xC3 with no `frame_err`.
